// File: rtl/tracklet_calculator_div_35s_18ns_18s.sv
// ----------------------------------------------------------------------------
// tracklet_calculator_div_35s_18ns_18s
//
// Multicycle restoring divider: 35-bit signed dividend / 18-bit unsigned
// divisor -> 18-bit signed quotient (truncated toward zero) and 19-bit signed
// remainder carrying the dividend's sign. The magnitude is divided one bit per
// cycle (35 steps), then the sign is re-applied and the result registered.
//
// Ports:
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only when idle)
//   din0, din1            dividend (signed), divisor (unsigned)
//   out_valid / out_ready result handshake (out_valid high only when done)
//   quot, rem             quotient / remainder, held until accepted
//   ovf                   quotient magnitude does not fit in 18 signed bits
//   dbz                   divisor was zero
//
// Parameters: ID (instance tag, no functional effect), NUM_ITER (must be 35).
//
// Build option: define TC_DIV_SATURATE_EN to saturate the quotient (and zero
// the remainder) on overflow; otherwise the quotient wraps to its low 18 bits.
// ----------------------------------------------------------------------------
module tracklet_calculator_div_35s_18ns_18s #(
    parameter int ID       = 1,
    parameter int NUM_ITER = 35
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [34:0] din0,
    input  logic [17:0] din1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] quot,
    output logic [18:0] rem,
    output logic        ovf,
    output logic        dbz
);

    // ID has no functional effect; the zero-weighted term keeps it referenced.
    localparam int CNT_W = $clog2(NUM_ITER) + 0 * ID;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [17:0] QUOT_POS_SAT = 18'h1FFFF;  // +131071
    localparam logic [17:0] QUOT_NEG_SAT = 18'h20000;  // -131072

    state_e             state_q, state_d;
    logic [34:0]        dvd_q, dvd_d;      // dividend magnitude, consumed MSB first
    logic               neg_q, neg_d;      // dividend sign
    logic [17:0]        dvs_q, dvs_d;      // divisor
    // The partial remainder is always below the divisor between steps, so 18
    // bits hold it; the 19th bit only exists in the shifted value below.
    logic [17:0]        part_q, part_d;
    logic [33:0]        quo_q, quo_d;      // quotient bits collected so far
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [17:0]        quot_q, quot_d;
    logic [18:0]        rem_q, rem_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    // One restoring step plus the signed result it would produce if it were
    // the last one.
    logic [18:0] shifted;
    logic [17:0] diff;
    logic        q_bit;
    logic [17:0] part_next;
    logic [34:0] q_mag;
    logic [17:0] q_wrap;
    logic [18:0] r_signed;
    logic        ovf_calc;
    logic [17:0] q_sat;
    logic        zero_dvs;

    always_comb begin
        shifted   = {part_q, dvd_q[34]};
        q_bit     = (shifted >= {1'b0, dvs_q});
        // Only used when q_bit is set; the true difference is below 2^18 then.
        diff      = shifted[17:0] - dvs_q;
        part_next = q_bit ? diff : shifted[17:0];
        q_mag     = {quo_q, q_bit};
        q_wrap    = neg_q ? (~q_mag[17:0] + 18'd1) : q_mag[17:0];
        r_signed  = neg_q ? (~{1'b0, part_next} + 19'd1) : {1'b0, part_next};
        ovf_calc  = neg_q ? (q_mag > 35'd131072) : (q_mag > 35'd131071);
        q_sat     = neg_q ? QUOT_NEG_SAT : QUOT_POS_SAT;
        zero_dvs  = (dvs_q == 18'd0);
    end

    // NOTE: every signal gets a hold default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        neg_d   = neg_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    neg_d   = din0[34];
                    // |-2^34| = 2^34 still fits in 35 unsigned bits.
                    dvd_d   = din0[34] ? (~din0 + 35'd1) : din0;
                    dvs_d   = din1;
                    part_d  = '0;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(NUM_ITER - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                dvd_d  = {dvd_q[33:0], 1'b0};
                part_d = part_next;
                quo_d  = q_mag[33:0];
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (zero_dvs) begin
                        quot_d = q_sat;
                        rem_d  = '0;
                        ovf_d  = 1'b0;
                        dbz_d  = 1'b1;
                    end else begin
                        ovf_d  = ovf_calc;
                        dbz_d  = 1'b0;
`ifdef TC_DIV_SATURATE_EN
                        quot_d = ovf_calc ? q_sat : q_wrap;
                        rem_d  = ovf_calc ? 19'd0 : r_signed;
`else
                        quot_d = q_wrap;
                        rem_d  = r_signed;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    quot_d  = '0;
                    rem_d   = '0;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    // NOTE: the datapath is reloaded on every input handshake and never
    // observed outside RUN, so it carries no reset.
    always_ff @(posedge ap_clk) begin
        dvd_q  <= dvd_d;
        neg_q  <= neg_d;
        dvs_q  <= dvs_d;
        part_q <= part_d;
        quo_q  <= quo_d;
        cnt_q  <= cnt_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_tracklet_calculator_div_35s_18ns_18s.sv
`timescale 1ns/1ps
module tb_tracklet_calculator_div_35s_18ns_18s;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [34:0] din0;
    logic [17:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] quot;
    logic [18:0] rem;
    logic        ovf;
    logic        dbz;

    typedef struct packed {
        logic [17:0] quot;
        logic [18:0] rem;
        logic        ovf;
        logic        dbz;
    } exp_t;

    exp_t   sb_q[$];
    int     vecs = 0;
    int     errs = 0;
    longint edge_cnt = 0;

    tracklet_calculator_div_35s_18ns_18s #(.ID(1), .NUM_ITER(35)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem),
        .ovf      (ovf),
        .dbz      (dbz)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model built from native 64-bit signed arithmetic.
    function automatic exp_t model(input logic [34:0] d0, input logic [17:0] d1);
        exp_t   e;
        longint a, b, q, r;
        a = longint'($signed(d0));
        b = longint'({1'b0, d1});
        if (b == 0) begin
            e.dbz  = 1'b1;
            e.ovf  = 1'b0;
            e.rem  = '0;
            e.quot = (a < 0) ? 18'h20000 : 18'h1FFFF;
        end else begin
            q      = a / b;
            r      = a % b;
            e.dbz  = 1'b0;
            e.ovf  = (q > 131071) || (q < -131072);
            e.quot = q[17:0];
            e.rem  = r[18:0];
`ifdef TC_DIV_SATURATE_EN
            if (e.ovf) begin
                e.quot = (a < 0) ? 18'h20000 : 18'h1FFFF;
                e.rem  = '0;
            end
`endif
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic send(input logic [34:0] d0, input logic [17:0] d1, output longint hs_edge);
        logic [63:0] junk;
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL send_in_ready: got %b required 1", in_ready);
        end
        din0     = d0;
        din1     = d1;
        in_valid = 1'b1;
        sb_q.push_back(model(d0, d1));
        @(posedge ap_clk);
        #1;
        hs_edge  = edge_cnt;
        in_valid = 1'b0;
        junk     = {$urandom(), $urandom()};
        din0     = junk[34:0];
        din1     = junk[17:0];
        @(negedge ap_clk);
    endtask

    // Scoreboard consumer: waits for the result, compares against the queue
    // head, holds out_ready low for `hold` cycles, then completes the handshake.
    task automatic collect(input string name, input int hold, output longint res_edge);
        int   lat;
        exp_t e;
        logic [17:0] q0;
        logic [18:0] r0;
        logic o0, z0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            vecs++;
            if (in_ready !== 1'b0) begin
                errs++;
                $display("FAIL %s run_in_ready: got %b required 0 at cycle %0d", name, in_ready, lat);
            end
            @(negedge ap_clk);
            lat++;
        end
        res_edge = edge_cnt;
        e = sb_q.pop_front();
        vecs++;
        if (out_valid !== 1'b1) begin
            errs++;
            $display("FAIL %s timeout: out_valid got %b required 1", name, out_valid);
            return;
        end
        vecs++;
        if (lat != 36) begin
            errs++;
            $display("FAIL %s latency: got %0d required 36", name, lat);
        end
        vecs++;
        if (quot !== e.quot) begin
            errs++;
            $display("FAIL %s quot: got %0d required %0d", name, $signed(quot), $signed(e.quot));
        end
        vecs++;
        if (rem !== e.rem) begin
            errs++;
            $display("FAIL %s rem: got %0d required %0d", name, $signed(rem), $signed(e.rem));
        end
        vecs++;
        if (ovf !== e.ovf || dbz !== e.dbz) begin
            errs++;
            $display("FAIL %s flags: got ovf=%b dbz=%b required ovf=%b dbz=%b",
                     name, ovf, dbz, e.ovf, e.dbz);
        end
        q0 = quot; r0 = rem; o0 = ovf; z0 = dbz;
        for (int i = 0; i < hold; i++) begin
            vecs++;
            if (quot !== q0 || rem !== r0 || ovf !== o0 || dbz !== z0 ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL %s hold: got quot=%h rem=%h ov=%b in_ready=%b required quot=%h rem=%h ov=1 in_ready=0",
                         name, quot, rem, out_valid, in_ready, q0, r0);
            end
            @(negedge ap_clk);
        end
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        @(negedge ap_clk);
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vecs++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== 18'd0 ||
            rem !== 19'd0 || ovf !== 1'b0 || dbz !== 1'b0) begin
            errs++;
            $display("FAIL %s: got in_ready=%b out_valid=%b quot=%h rem=%h ovf=%b dbz=%b required 1 0 0 0 0 0",
                     name, in_ready, out_valid, quot, rem, ovf, dbz);
        end
    endtask

    task automatic test_reset();
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        check_reset_outputs("reset_state");
    endtask

    task automatic test_basic();
        longint h, r;
        send(35'sd1000, 18'd7, h);
        collect("pos_1000_7", 0, r);
        send(-35'sd1000, 18'd7, h);
        collect("neg_1000_7", 2, r);
        send(35'h4_0000_0000, 18'd131072, h);   // -2^34 / 2^17
        collect("neg_min_boundary", 0, r);
        send(35'sd0, 18'd5, h);
        collect("zero_dividend", 0, r);
    endtask

    task automatic test_overflow();
        longint h, r;
        send(35'h3_FFFF_FFFF, 18'd1, h);        // 2^34 - 1
        collect("ovf_pos", 1, r);
        send(35'sd131072, 18'd1, h);            // one past the positive limit
        collect("ovf_pos_edge", 0, r);
        send(-35'sd131073, 18'd1, h);           // one past the negative limit
        collect("ovf_neg_edge", 0, r);
        send(35'h4_0000_0000, 18'd1, h);
        collect("ovf_neg_min", 0, r);
    endtask

    task automatic test_dbz();
        longint h, r;
        send(35'sd5, 18'd0, h);
        collect("dbz_pos", 0, r);
        send(-35'sd5, 18'd0, h);
        collect("dbz_neg", 0, r);
    endtask

    task automatic test_back_to_back();
        longint h0, h1, r0, r1;
        send(35'sd123456789, 18'd1000, h0);
        collect("b2b_first", 10, r0);
        send(-35'sd987654, 18'd77, h1);
        collect("b2b_second", 0, r1);
        vecs++;
        if (r1 - h0 + 1 != 83) begin
            errs++;
            $display("FAIL b2b_second_cycle: got %0d required 83", r1 - h0 + 1);
        end
    endtask

    task automatic test_reset_mid_op();
        longint h, r;
        send(35'sd999, 18'd3, h);
        repeat (19) @(negedge ap_clk);          // now in cycle 20
        ap_rst = 1'b1;
        @(negedge ap_clk);                      // cycle 21
        ap_rst = 1'b0;
        check_reset_outputs("reset_in_run");
        sb_q.delete();
        send(35'sd1000, 18'd7, h);
        collect("after_reset_run", 0, r);
        // Reset while the result is being presented.
        send(-35'sd4444, 18'd9, h);
        repeat (36) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        check_reset_outputs("reset_in_done");
        sb_q.delete();
    endtask

    task automatic test_random();
        longint      h, r;
        logic [63:0] v;
        logic [34:0] d0;
        logic [17:0] d1;
        for (int i = 0; i < 8; i++) begin
            v  = {$urandom(), $urandom()};
            d0 = v[34:0];
            d0 = 35'($signed(d0) >>> $urandom_range(0, 20));
            d1 = 18'($urandom_range(1, 262143));
            send(d0, d1, h);
            collect("random", int'($urandom_range(0, 3)), r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_dbz();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
